// File: rtl/fwd_pkg.sv
// Shared types and select encoding for the operand-forwarding sequencer.
// A history entry describes one issue slot: whether it holds a producer, and which register it writes.
package fwd_pkg;

  localparam int AW    = 5;
  localparam int DEPTH = 3;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          is_load;
    logic [AW-1:0] rd;
  } hist_entry_t;

  localparam hist_entry_t HIST_BUBBLE = '0;

  function automatic logic hist_match(input hist_entry_t e, input logic [AW-1:0] r);
    return e.valid & e.we & (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority compare of one source address against the three in-flight producers.
// Purely combinational; the youngest matching producer selects the forwarding path.
module fwd_select
  import fwd_pkg::*;
(
  input  hist_entry_t   i_h1,
  input  hist_entry_t   i_h2,
  input  hist_entry_t   i_h3,
  input  logic [AW-1:0] i_src,
  input  logic          i_use,
  output logic [1:0]    o_sel,
  output logic          o_load_haz
);

  logic w_m1;
  logic w_m2;
  logic w_m3;

  assign w_m1 = i_use & hist_match(i_h1, i_src);
  assign w_m2 = i_use & hist_match(i_h2, i_src);
  assign w_m3 = i_use & hist_match(i_h3, i_src);

  always_comb begin
    o_sel = SEL_RF;
    if (w_m1) begin
      o_sel = SEL_EX;
    end else if (w_m2) begin
      o_sel = SEL_DM;
    end else if (w_m3) begin
      o_sel = SEL_WB;
    end
  end

  // A load at distance 1 has no result on ans_ex yet, so its consumer must wait a cycle.
  assign o_load_haz = w_m1 & i_h1.is_load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-select sequencer: tracks the last three issue slots, drives registered forwarding selects
// one cycle after issue, and stalls decode for one cycle on a load-use hazard.
module fwd_hazard_ctrl
  import fwd_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_ra,
  input  logic [AW-1:0] id_rb,
  input  logic          id_use_ra,
  input  logic          id_use_rb,
  input  logic          id_use_imm,
  input  logic [AW-1:0] id_rd,
  input  logic          id_rd_we,
  input  logic          id_is_load,
  input  logic          flush,
  output logic [1:0]    mux_sel_A,
  output logic [1:0]    mux_sel_B,
  output logic          imm_sel,
  output logic          stall,
  output logic          issue
);

  hist_entry_t r_hist [DEPTH];
  logic [1:0]  r_sel_a;
  logic [1:0]  r_sel_b;
  logic        r_imm_sel;

  logic        w_use_b;
  logic [1:0]  w_sel_a;
  logic [1:0]  w_sel_b;
  logic        w_haz_a;
  logic        w_haz_b;
  hist_entry_t w_new_entry;

  // An immediate B operand never reads the register bank, so it neither forwards nor hazards.
  assign w_use_b = id_use_rb & ~id_use_imm;

  fwd_select u_sel_a (
    .i_h1       (r_hist[0]),
    .i_h2       (r_hist[1]),
    .i_h3       (r_hist[2]),
    .i_src      (id_ra),
    .i_use      (id_use_ra),
    .o_sel      (w_sel_a),
    .o_load_haz (w_haz_a)
  );

  fwd_select u_sel_b (
    .i_h1       (r_hist[0]),
    .i_h2       (r_hist[1]),
    .i_h3       (r_hist[2]),
    .i_src      (id_rb),
    .i_use      (w_use_b),
    .o_sel      (w_sel_b),
    .o_load_haz (w_haz_b)
  );

  assign stall = id_valid & ~flush & (w_haz_a | w_haz_b);
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    w_new_entry         = HIST_BUBBLE;
    w_new_entry.valid   = 1'b1;
    w_new_entry.we      = id_rd_we;
    w_new_entry.is_load = id_is_load;
    w_new_entry.rd      = id_rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_hist[i] <= HIST_BUBBLE;
      end
      r_sel_a   <= SEL_RF;
      r_sel_b   <= SEL_RF;
      r_imm_sel <= 1'b0;
    end else begin
      r_hist[0] <= issue ? w_new_entry : HIST_BUBBLE;
      // The instruction squashed by flush must never be seen as a producer downstream.
      r_hist[1] <= flush ? HIST_BUBBLE : r_hist[0];
      for (int i = 2; i < DEPTH; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
      r_sel_a   <= issue ? w_sel_a : SEL_RF;
      r_sel_b   <= issue ? w_sel_b : SEL_RF;
      r_imm_sel <= issue & id_use_imm;
    end
  end

  assign mux_sel_A = r_sel_a;
  assign mux_sel_B = r_sel_b;
  assign imm_sel   = r_imm_sel;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, hand-written reset sequences,
// and random traffic compared against a slot-history reference model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic       id_use_ra;
  logic       id_use_rb;
  logic       id_use_imm;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_is_load;
  logic       flush;
  logic [1:0] mux_sel_A;
  logic [1:0] mux_sel_B;
  logic       imm_sel;
  logic       stall;
  logic       issue;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_use_ra  (id_use_ra),
    .id_use_rb  (id_use_rb),
    .id_use_imm (id_use_imm),
    .id_rd      (id_rd),
    .id_rd_we   (id_rd_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .mux_sel_A  (mux_sel_A),
    .mux_sel_B  (mux_sel_B),
    .imm_sel    (imm_sel),
    .stall      (stall),
    .issue      (issue)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: slot s[1] is the most recent issue slot, s[3] the oldest tracked.
  typedef struct {
    bit       v;
    bit       we;
    bit       ld;
    bit [4:0] rd;
  } slot_t;

  slot_t s[1:3];
  int    m_sa = 0, m_sb = 0, m_im = 0;
  int    m_st, m_is;

  // Returns the distance of the youngest producer of r (1..3), which equals the select code.
  function automatic int m_dist(input bit [4:0] r, input bit use_it);
    if (!use_it) return 0;
    for (int d = 1; d <= 3; d++)
      if (s[d].v && s[d].we && s[d].rd == r) return d;
    return 0;
  endfunction

  function automatic int m_stall_now();
    bit use_b;
    bit ha;
    bit hb;
    use_b = id_use_rb && !id_use_imm;
    if (!id_valid || flush) return 0;
    ha = m_dist(id_ra, id_use_ra) == 1 && s[1].ld;
    hb = m_dist(id_rb, use_b) == 1 && s[1].ld;
    return int'(ha || hb);
  endfunction

  function automatic void m_advance(input int is_now);
    slot_t bubble;
    bubble = '{v: 1'b0, we: 1'b0, ld: 1'b0, rd: 5'd0};
    if (!rst_n) begin
      for (int d = 1; d <= 3; d++) s[d] = bubble;
      m_sa = 0; m_sb = 0; m_im = 0;
    end else begin
      m_sa = is_now ? m_dist(id_ra, id_use_ra) : 0;
      m_sb = is_now ? m_dist(id_rb, id_use_rb && !id_use_imm) : 0;
      m_im = is_now ? int'(id_use_imm) : 0;
      s[3] = s[2];
      s[2] = flush ? bubble : s[1];
      s[1] = is_now ? '{v: 1'b1, we: id_rd_we, ld: id_is_load, rd: id_rd} : bubble;
    end
  endfunction

  task automatic drive(input bit rst, input bit vld, input bit ura, input bit [4:0] ra,
                       input bit urb, input bit [4:0] rb, input bit imm,
                       input bit we, input bit [4:0] rd, input bit ld, input bit fl);
    rst_n = rst; id_valid = vld; id_use_ra = ura; id_ra = ra; id_use_rb = urb; id_rb = rb;
    id_use_imm = imm; id_rd_we = we; id_rd = rd; id_is_load = ld; flush = fl;
  endtask

  // Called right after a negedge drive; samples combinational outputs mid-low-phase and
  // registered outputs 1 time unit after the rising edge, then returns at the next negedge.
  task automatic run_cycle(output int o_st, output int o_is, output int o_sa,
                           output int o_sb, output int o_im);
    #1;
    o_st = int'(stall);
    o_is = int'(issue);
    m_st = m_stall_now();
    m_is = int'(id_valid && !flush && m_st == 0);
    m_advance(m_is);
    @(posedge clk);
    #1;
    o_sa = int'(mux_sel_A);
    o_sb = int'(mux_sel_B);
    o_im = int'(imm_sel);
    @(negedge clk);
  endtask

  typedef struct {
    string    nm;
    bit       vld, ura, urb, imm, we, ld, fl;
    bit [4:0] ra, rb, rd;
    int       e_st, e_is, e_sa, e_sb, e_im;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input bit vld, input bit ura, input bit [4:0] ra,
                              input bit urb, input bit [4:0] rb, input bit imm, input bit we,
                              input bit [4:0] rd, input bit ld, input bit fl,
                              input int e_st, input int e_is, input int e_sa, input int e_sb,
                              input int e_im);
    vec_t v;
    v.nm = nm; v.vld = vld; v.ura = ura; v.ra = ra; v.urb = urb; v.rb = rb; v.imm = imm;
    v.we = we; v.rd = rd; v.ld = ld; v.fl = fl;
    v.e_st = e_st; v.e_is = e_is; v.e_sa = e_sa; v.e_sb = e_sb; v.e_im = e_im;
    return v;
  endfunction

  initial begin
    int a_st, a_is, a_sa, a_sb, a_im;

    //             name          vld ura ra urb rb imm we rd ld fl  st is sa sb im
    tbl.push_back(mk("prod5_a",    1, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("nop_a1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("nop_a2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("dist3",      1, 1, 5, 0, 0, 0, 0, 1, 0, 0,  0, 1, 3, 0, 0));
    tbl.push_back(mk("prod5_b",    1, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("nop_b",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("dist2",      1, 1, 5, 0, 0, 0, 0, 1, 0, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk("prod5_c",    1, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("dist1",      1, 1, 5, 0, 0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk("pri_x",      1, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("pri_y",      1, 0, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("pri_use",    1, 0, 0, 1, 3, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0));
    tbl.push_back(mk("load7",      1, 0, 0, 0, 0, 0, 1, 7, 1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("lu_stall",   1, 1, 7, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk("lu_retry",   1, 1, 7, 0, 0, 0, 0, 1, 0, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk("prod9",      1, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("flush",      1, 1, 9, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("post_flush", 1, 1, 9, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("prod4",      1, 0, 0, 0, 0, 0, 1, 4, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("imm_b4",     1, 0, 0, 1, 4, 1, 0, 1, 0, 0,  0, 1, 0, 0, 1));
    tbl.push_back(mk("nowe6",      1, 0, 0, 0, 0, 0, 0, 6, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("use_nowe6",  1, 1, 6, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("load8",      1, 0, 0, 0, 0, 0, 1, 8, 1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("flush_ovr",  1, 1, 8, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("post_ovr",   1, 1, 8, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("load2",      1, 0, 0, 0, 0, 0, 1, 2, 1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("imm_ld2",    1, 0, 0, 1, 2, 1, 0, 1, 0, 0,  0, 1, 0, 0, 1));
    tbl.push_back(mk("prod_r0",    1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk("use_r0",     1, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0, 1, 1, 1, 0));

    for (int d = 1; d <= 3; d++) s[d] = '{v: 1'b0, we: 1'b0, ld: 1'b0, rd: 5'd0};

    // Reset held two cycles with a valid instruction presented.
    @(negedge clk);
    drive(0, 1, 1, 5'd1, 1, 5'd2, 0, 1, 5'd3, 0, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    check("rst1.sel_a", a_sa, 0);
    check("rst1.sel_b", a_sb, 0);
    check("rst1.imm", a_im, 0);
    drive(0, 1, 1, 5'd3, 1, 5'd3, 1, 1, 5'd3, 1, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    check("rst2.stall", a_st, 0);
    check("rst2.sel_a", a_sa, 0);
    check("rst2.imm", a_im, 0);
    drive(1, 1, 1, 5'd3, 1, 5'd3, 0, 0, 5'd1, 0, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    check("rst_after.stall", a_st, 0);
    check("rst_after.sel_a", a_sa, 0);
    check("rst_after.sel_b", a_sb, 0);

    foreach (tbl[i]) begin
      drive(1, tbl[i].vld, tbl[i].ura, tbl[i].ra, tbl[i].urb, tbl[i].rb, tbl[i].imm,
            tbl[i].we, tbl[i].rd, tbl[i].ld, tbl[i].fl);
      run_cycle(a_st, a_is, a_sa, a_sb, a_im);
      check({tbl[i].nm, ".stall"}, a_st, tbl[i].e_st);
      check({tbl[i].nm, ".issue"}, a_is, tbl[i].e_is);
      check({tbl[i].nm, ".sel_a"}, a_sa, tbl[i].e_sa);
      check({tbl[i].nm, ".sel_b"}, a_sb, tbl[i].e_sb);
      check({tbl[i].nm, ".imm"}, a_im, tbl[i].e_im);
    end

    // Reset mid-operation must discard an in-flight load: no stall and no forwarding afterwards.
    drive(1, 1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 1, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    drive(1, 1, 1, 5'd7, 1, 5'd7, 0, 0, 5'd1, 0, 0);
    run_cycle(a_st, a_is, a_sa, a_sb, a_im);
    check("midrst.stall", a_st, 0);
    check("midrst.issue", a_is, 1);
    check("midrst.sel_a", a_sa, 0);
    check("midrst.sel_b", a_sb, 0);

    // Random traffic over a small register window so producers and consumers collide often.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(99) >= 2, $urandom_range(99) < 80,
            1'($urandom_range(1)), 5'($urandom_range(7)),
            1'($urandom_range(1)), 5'($urandom_range(7)),
            $urandom_range(99) < 25, $urandom_range(99) < 80, 5'($urandom_range(7)),
            $urandom_range(99) < 30, $urandom_range(99) < 8);
      run_cycle(a_st, a_is, a_sa, a_sb, a_im);
      check($sformatf("rnd%0d.stall", n), a_st, m_st);
      check($sformatf("rnd%0d.issue", n), a_is, m_is);
      check($sformatf("rnd%0d.sel_a", n), a_sa, m_sa);
      check($sformatf("rnd%0d.sel_b", n), a_sb, m_sb);
      check($sformatf("rnd%0d.imm", n), a_im, m_im);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
